// File: rtl/sobel_frame_loader_if.sv
// Pixel-stream / SRAM1-write / frame-handshake bundle between a pixel source,
// the frame loader and the sobelFilter.
//   getNext      : filter asks for the next frame
//   pixData/pixValid/pixSof/pixReady : 8-bit pixel stream with start-of-frame
//   we1/write_addr1/data1 : SRAM1 write port, one 64-bit word per strobe
//   startEn      : one-cycle pulse, frame resident in SRAM1
//   loadBusy     : loader is filling a frame
//   syncErr      : sticky start-of-frame alignment error
// The slave modport is the loader; master is the stream/filter side.
interface sobel_frame_loader_if #(
  parameter int ADDR_W = 20
);
  logic              getNext;
  logic [7:0]        pixData;
  logic              pixValid;
  logic              pixSof;
  logic              pixReady;
  logic              we1;
  logic [ADDR_W-1:0] write_addr1;
  logic [63:0]       data1;
  logic              startEn;
  logic              loadBusy;
  logic              syncErr;

  modport master (
    output getNext, pixData, pixValid, pixSof,
    input  pixReady, we1, write_addr1, data1, startEn, loadBusy, syncErr
  );

  modport slave (
    input  getNext, pixData, pixValid, pixSof,
    output pixReady, we1, write_addr1, data1, startEn, loadBusy, syncErr
  );
endinterface

// File: rtl/sobel_frame_loader.sv
// Frame loader feeding sobelFilter: packs an 8-bit pixel stream MSB-first into
// 64-bit words, writes a whole frame into SRAM1, then pulses startEn. A new
// frame is loaded on getNext (requests seen while busy are remembered).
// Ports:
//   clk   : system clock, posedge
//   reset : synchronous, active-high
//   bus   : sobel_frame_loader_if.slave (pixel stream, SRAM1 write, handshake)
module sobel_frame_loader #(
  parameter int FRAME_WORDS = 32768,
  parameter int ADDR_W      = 20,
  parameter int AUTO_START  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sobel_frame_loader_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [2:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [55:0]       pack_q, pack_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic              last_q, last_d;
  logic              sync_q, sync_d;
  logic              ready_q, busy_q, start_q;
  logic              xfer, at_start;

  assign xfer     = bus.pixValid && ready_q;
  assign at_start = (byte_q == 3'd0) && (wcnt_q == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    byte_d    = byte_q;
    wcnt_d    = wcnt_q;
    pack_d    = pack_q;
    we1_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    sync_d    = sync_q;
    case (state_q)
      IDLE: begin
        if (bus.getNext || pending_q) begin
          state_d   = FILL;
          pending_d = 1'b0;
        end
      end
      FILL: begin
        if (bus.getNext) pending_d = 1'b1;
        // last_q marks the cycle the final word is on the SRAM port; stream is
        // stalled during it so no pixel can spill past the frame.
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else if (xfer) begin
          if (at_start && !bus.pixSof) begin
            // Frame must open with pixSof: drop the pixel.
            sync_d = 1'b1;
          end else if (bus.pixSof && !at_start) begin
            // Unexpected start-of-frame: discard partial word, restart frame.
            sync_d = 1'b1;
            pack_d = {pack_q[47:0], bus.pixData};
            byte_d = 3'd1;
            wcnt_d = '0;
          end else begin
            pack_d = {pack_q[47:0], bus.pixData};
            if (byte_q == 3'd7) begin
              we1_d  = 1'b1;
              data_d = {pack_q, bus.pixData};
              addr_d = wcnt_q;
              byte_d = 3'd0;
              if (wcnt_q == LAST_ADDR) begin
                wcnt_d = '0;
                last_d = 1'b1;
              end else begin
                wcnt_d = wcnt_q + 1'b1;
              end
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end
        end
      end
      DONE: begin
        if (bus.getNext) pending_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (AUTO_START != 0) ? FILL : IDLE;
      pending_q <= 1'b0;
      byte_q    <= 3'd0;
      wcnt_q    <= '0;
      we1_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      sync_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      byte_q    <= byte_d;
      wcnt_q    <= wcnt_d;
      we1_q     <= we1_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      sync_q    <= sync_d;
      // Status outputs are registered from the next state.
      ready_q   <= (state_d == FILL) && !last_d;
      busy_q    <= (state_d == FILL);
      start_q   <= (state_d == DONE);
    end
    pack_q <= pack_d;
  end

  assign bus.pixReady    = ready_q;
  assign bus.we1         = we1_q;
  assign bus.write_addr1 = addr_q;
  assign bus.data1       = data_q;
  assign bus.startEn     = start_q;
  assign bus.loadBusy    = busy_q;
  assign bus.syncErr     = sync_q;

endmodule

// File: tb/tb_sobel_frame_loader.sv
module tb_sobel_frame_loader;
  localparam int FW = 4;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_frame_loader_if #(.ADDR_W(AW)) bus ();

  sobel_frame_loader #(.FRAME_WORDS(FW), .ADDR_W(AW), .AUTO_START(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every SRAM write is matched against the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (bus.we1 === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%016h", bus.write_addr1, bus.data1);
      end else begin
        e = exp_q.pop_front();
        if (bus.write_addr1 !== e.addr || bus.data1 !== e.data) begin
          errors++;
          $display("FAIL write got addr=%0h data=%016h exp addr=%0h data=%016h",
                   bus.write_addr1, bus.data1, e.addr, e.data);
        end
      end
    end
    if (bus.startEn === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] word_of(input logic [7:0] b);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = b + 8'(i);
    return w;
  endfunction

  task automatic push_word(input int a, input logic [63:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int w = 0; w < FW; w++) push_word(w, word_of(b + 8'(8 * w)));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a posedge; returns in the same phase.
  task automatic send_pix(input logic [7:0] d, input logic sof, input logic gn);
    int n;
    bus.pixData  = d;
    bus.pixSof   = sof;
    bus.pixValid = 1'b1;
    bus.getNext  = gn;
    n = 0;
    while (bus.pixReady !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL pix_accept_timeout pixReady=%b expected 1", bus.pixReady);
    end else begin
      tick(1);
    end
    bus.pixValid = 1'b0;
    bus.pixSof   = 1'b0;
    bus.getNext  = 1'b0;
  endtask

  task automatic stream(input logic [7:0] b, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      send_pix(b + 8'(i), (i == 0), 1'b0);
      if (toggle) tick(1);
    end
  endtask

  task automatic wait_start(input string name);
    int s, n;
    s = start_cnt;
    n = 0;
    while (start_cnt == s && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (start_cnt == s) begin
      errors++;
      $display("FAIL %s startEn_timeout count=%0d expected %0d", name, start_cnt, s + 1);
    end
  endtask

  task automatic pulse_getnext();
    bus.getNext = 1'b1;
    tick(1);
    bus.getNext = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.we1, bus.startEn, bus.loadBusy, bus.syncErr, bus.pixReady} !== 5'b0 ||
        bus.write_addr1 !== '0 || bus.data1 !== 64'h0) begin
      errors++;
      $display("FAIL %s outputs we1=%b st=%b busy=%b se=%b rdy=%b addr=%0h data=%016h expected all 0",
               name, bus.we1, bus.startEn, bus.loadBusy, bus.syncErr, bus.pixReady,
               bus.write_addr1, bus.data1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.loadBusy !== 1'b1 || bus.pixReady !== 1'b1) begin
      errors++;
      $display("FAIL autostart busy=%b rdy=%b expected 1 1", bus.loadBusy, bus.pixReady);
    end
  endtask

  task automatic test_first_frame();
    int w0, s0;
    w0 = we_cnt;
    s0 = start_cnt;
    push_frame(8'h00);
    stream(8'h00, 32, 1'b0);
    wait_start("first_frame");
    checks++;
    if (start_cyc !== last_we_cyc + 1) begin
      errors++;
      $display("FAIL start_latency startcyc=%0d expected %0d", start_cyc, last_we_cyc + 1);
    end
    checks++;
    if (bus.pixReady !== 1'b0 || bus.loadBusy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done rdy=%b busy=%b expected 0 0", bus.pixReady, bus.loadBusy);
    end
    tick(3);
    checks++;
    if (start_cnt - s0 !== 1 || we_cnt - w0 !== FW) begin
      errors++;
      $display("FAIL pulse_counts starts=%0d writes=%0d expected 1 %0d",
               start_cnt - s0, we_cnt - w0, FW);
    end
    checks++;
    if (bus.data1 !== 64'h18191A1B1C1D1E1F || bus.write_addr1 !== AW'(3)) begin
      errors++;
      $display("FAIL hold data=%016h addr=%0h expected 18191a1b1c1d1e1f 3", bus.data1, bus.write_addr1);
    end
  endtask

  task automatic test_getnext_idle();
    pulse_getnext();
    checks++;
    if (bus.loadBusy !== 1'b1 || bus.pixReady !== 1'b1) begin
      errors++;
      $display("FAIL getnext_fill busy=%b rdy=%b expected 1 1", bus.loadBusy, bus.pixReady);
    end
    push_frame(8'h40);
    stream(8'h40, 32, 1'b0);
    wait_start("getnext_idle");
  endtask

  task automatic test_back_to_back();
    pulse_getnext();
    push_frame(8'h80);
    for (int i = 0; i < 32; i++) send_pix(8'h80 + 8'(i), (i == 0), (i == 5 || i == 20));
    wait_start("b2b_first");
    checks++;
    if (bus.loadBusy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b expected 0", bus.loadBusy);
    end
    tick(1);
    checks++;
    if (bus.loadBusy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending busy=%b expected 1", bus.loadBusy);
    end
    push_frame(8'hA0);
    stream(8'hA0, 32, 1'b0);
    wait_start("b2b_second");
    tick(5);
    checks++;
    if (bus.loadBusy !== 1'b0 || bus.pixReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third busy=%b rdy=%b expected 0 0", bus.loadBusy, bus.pixReady);
    end
  endtask

  task automatic test_toggle();
    int w0;
    w0 = we_cnt;
    pulse_getnext();
    push_frame(8'h00);
    stream(8'h00, 32, 1'b1);
    wait_start("toggle");
    checks++;
    if (we_cnt - w0 !== FW) begin
      errors++;
      $display("FAIL toggle_writes count=%0d expected %0d", we_cnt - w0, FW);
    end
  endtask

  task automatic test_sync();
    pulse_getnext();
    push_word(0, word_of(8'h00));
    push_frame(8'h0B);
    for (int i = 0; i < 11; i++) send_pix(8'(i), (i == 0), 1'b0);
    checks++;
    if (bus.syncErr !== 1'b0) begin
      errors++;
      $display("FAIL sync_before se=%b expected 0", bus.syncErr);
    end
    stream(8'h0B, 32, 1'b0);
    wait_start("sync");
    checks++;
    if (bus.syncErr !== 1'b1) begin
      errors++;
      $display("FAIL sync_err se=%b expected 1", bus.syncErr);
    end
  endtask

  task automatic test_reset_midframe();
    int w0;
    pulse_getnext();
    push_word(0, word_of(8'h50));
    for (int i = 0; i < 13; i++) send_pix(8'h50 + 8'(i), (i == 0), 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midframe_word0 pending=%0d expected 0", exp_q.size());
    end
    w0 = we_cnt;
    reset = 1'b1;
    tick(1);
    check_outputs_zero("midframe_reset");
    tick(1);
    reset = 1'b0;
    tick(3);
    checks++;
    if (we_cnt !== w0) begin
      errors++;
      $display("FAIL partial_written writes=%0d expected %0d", we_cnt, w0);
    end
    send_pix(8'hEE, 1'b0, 1'b0);
    checks++;
    if (bus.syncErr !== 1'b1) begin
      errors++;
      $display("FAIL missing_sof se=%b expected 1", bus.syncErr);
    end
    push_frame(8'h60);
    stream(8'h60, 32, 1'b0);
    wait_start("reload");
  endtask

  initial begin
    reset        = 1'b1;
    bus.getNext  = 1'b0;
    bus.pixData  = 8'h00;
    bus.pixValid = 1'b0;
    bus.pixSof   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_frame();
    test_getnext_idle();
    test_back_to_back();
    test_toggle();
    test_sync();
    test_reset_midframe();
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_frame_loader.md
Name: sobel_frame_loader

Overview:
- Upstream end of the getNext/startEn handshake used by sobelFilter.
- Accepts an 8-bit pixel stream and packs 8 pixels into each 64-bit word. Writes whole frames into SRAM1 (the we1/write_addr1/data1 port).
- When a frame is complete, pulses startEn so the filter begins reading that frame.
- Responds to getNext by loading the next frame.

Parameters:
FRAME_WORDS, 32768, 64-bit words per frame (512x512 pixels / 8)
ADDR_W, 20, SRAM address width
AUTO_START, 1, 1 = load the first frame after reset without waiting for getNext

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
getNext  input  1  request from sobelFilter to load the next frame; sampled every cycle
pixData  input  8  incoming pixel
pixValid  input  1  pixData valid
pixSof  input  1  first pixel of frame, qualified by pixValid
pixReady  output  1  loader can accept a pixel this cycle
we1  output  1  SRAM1 write enable, one-cycle strobe per word
write_addr1  output  ADDR_W  SRAM1 word address
data1  output  64  packed word
startEn  output  1  one-cycle pulse: frame resident in SRAM1
loadBusy  output  1  high while in FILL
syncErr  output  1  sticky; pixSof misaligned or missing

Behaviour:
- Reset (synchronous): all outputs, byte index, word counter and the pending-request flag go to 0.
  - State goes to FILL if AUTO_START=1, else IDLE.
  - Reset mid-frame abandons the partial word; nothing further is written.
- Pixel transfer occurs when pixValid && pixReady. pixReady = 1 only in FILL, and 0 in the cycle a word is written only if write_addr1 would equal FRAME_WORDS.
- Packing is MSB-first:
  - Pixel k of a word (k=0..7) lands in bits [63-8k -: 8].
  - First pixel of the frame → data1[63:56] of address 0.
- Word write: the 8th transfer of a word sets we1=1 on the next cycle, with data1 = the packed word and write_addr1 = the word counter.
  - Latency is exactly 1 clk. we1 is high for exactly one cycle per word.
  - data1 and write_addr1 hold their values between writes.
- Word counter increments after each write.
  - After the write at FRAME_WORDS-1, the state goes to DONE and the counter clears to 0.
  - write_addr1 never exceeds FRAME_WORDS-1.
- FSM:
  - IDLE: pixReady=0, loadBusy=0. getNext=1 or pending=1 → FILL, and pending clears.
  - FILL: loadBusy=1. The last word written → DONE.
  - DONE: exactly 1 cycle. startEn=1 during it. → IDLE.
- getNext:
  - A level-high in any cycle while in FILL or DONE sets pending=1, so the request is never lost.
  - Multiple requests while busy collapse into one.
  - getNext in IDLE → FILL on the next cycle.
- Sync:
  - The first transfer in FILL at word 0 / byte 0 must carry pixSof=1. Otherwise the pixel is dropped and syncErr is set.
  - pixSof=1 at any other position: the partial word and counter are discarded and restart at byte 0 / word 0 with this pixel, and syncErr is set.
  - Nothing is written for the discarded data.
- pixValid outside FILL is ignored; no data is consumed.
- syncErr clears only on reset.

Test Plan:
- Reset with AUTO_START=1, FRAME_WORDS=4; stream 32 pixels 0x00..0x1F, pixSof on the first → four we1 pulses:
  - addr 0: data1=0x0001020304050607
  - ...
  - addr 3: data1=0x18191A1B1C1D1E1F
  - startEn is a single pulse 1 clk after the addr 3 write; then IDLE with pixReady=0.
- In IDLE, drive getNext=1 for 1 cycle, then a fresh frame → FILL next cycle; write_addr1 restarts at 0; second startEn pulse.
- getNext pulsed twice during FILL → exactly one extra frame load after DONE, with no gap beyond one IDLE cycle.
- Same 32-pixel frame with pixValid toggling 1/0 → identical data and addresses; we1 count = 4.
- Inject pixSof at pixel 11 → syncErr=1; the first write is at addr 0 with data starting at the re-synced pixel; no write of the discarded partial word.
- Assert reset after 13 pixels → we1 never pulses for the partial data; outputs 0; reload from pixSof gives correct addr 0 data.
